// File: rtl/load_store_unit_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | load_store_unit_pkg                                                        |
// | Shared funct3 codes, FSM states and store-lane helpers for the LSU.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package load_store_unit_pkg;

   localparam logic [2:0] c_f3_lb  = 3'b000;
   localparam logic [2:0] c_f3_lh  = 3'b001;
   localparam logic [2:0] c_f3_lw  = 3'b010;
   localparam logic [2:0] c_f3_lbu = 3'b100;
   localparam logic [2:0] c_f3_lhu = 3'b101;

   localparam logic [3:0] c_be_byte = 4'b0001;
   localparam logic [3:0] c_be_half = 4'b0011;
   localparam logic [3:0] c_be_word = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } lsu_state_e;

   // Unsigned loads have no store form, so BU/HU with we=1 are illegal too.
   function automatic logic access_err(input logic we, input logic [2:0] f3,
                                       input logic [1:0] lo);
      case (f3)
         c_f3_lb:  access_err = 1'b0;
         c_f3_lh:  access_err = lo[0];
         c_f3_lw:  access_err = |lo;
         c_f3_lbu: access_err = we;
         c_f3_lhu: access_err = we | lo[0];
         default:  access_err = 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         2'b00:   store_be = c_be_byte << lo;
         2'b01:   store_be = c_be_half << {lo[1], 1'b0};
         default: store_be = c_be_word;
      endcase
   endfunction

   function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] d);
      case (size)
         2'b00:   store_wdata = {4{d[7:0]}};
         2'b01:   store_wdata = {2{d[15:0]}};
         default: store_wdata = d;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | load_store_unit_if                                                         |
// | req/gnt/rvalid data-memory port between the LSU and data memory.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface load_store_unit_if #(
   parameter int ADDR_W = 32
) ();
   logic              dmem_req;
   logic              dmem_we;
   logic [ADDR_W-1:0] dmem_addr;
   logic [3:0]        dmem_be;
   logic [31:0]       dmem_wdata;
   logic              dmem_gnt;
   logic              dmem_rvalid;
   logic [31:0]       dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  dmem_gnt, dmem_rvalid, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output dmem_gnt, dmem_rvalid, dmem_rdata
   );
endinterface
`default_nettype wire

// File: rtl/load_store_unit_load_align.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu_load_align                                                             |
// | Selects the addressed byte/half of a memory word and sign/zero-extends it. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lsu_load_align
   import load_store_unit_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_addr_lo,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_rdata[7:0];
      case (i_addr_lo)
         2'd0: w_byte = i_rdata[7:0];
         2'd1: w_byte = i_rdata[15:8];
         2'd2: w_byte = i_rdata[23:16];
         2'd3: w_byte = i_rdata[31:24];
         default: w_byte = i_rdata[7:0];
      endcase
   end

   // Halfword loads only reach here aligned, so addr[1] alone picks the half.
   assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

   always_comb begin
      o_data = i_rdata;
      case (i_funct3)
         c_f3_lb:  o_data = {{24{w_byte[7]}}, w_byte};
         c_f3_lh:  o_data = {{16{w_half[15]}}, w_half};
         c_f3_lbu: o_data = {24'h000000, w_byte};
         c_f3_lhu: o_data = {16'h0000, w_half};
         default:  o_data = i_rdata;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | load_store_unit                                                            |
// | RV32I data-memory access stage: request FSM, store lanes, load alignment.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              lsu_valid,
   input  logic              lsu_we,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] alu_output,
   input  logic [DATA_W-1:0] store_data,
   output logic              lsu_busy,
   output logic              lsu_done,
   output logic              misalign_err,
   output logic [DATA_W-1:0] Mem_ReadData,
   load_store_unit_if.master dmem
);

   lsu_state_e        r_state;
   logic              r_we;
   logic [2:0]        r_funct3;
   logic [1:0]        r_addr_lo;
   logic [ADDR_W-1:0] r_addr;
   logic [3:0]        r_be;
   logic [31:0]       r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              r_req;
   logic              r_busy;
   logic              r_done;
   logic              r_misalign;

   logic              w_err;
   logic [31:0]       w_load_data;

   assign w_err = access_err(lsu_we, funct3, alu_output[1:0]);

   lsu_load_align u_load_align (
      .i_rdata   (dmem.dmem_rdata),
      .i_addr_lo (r_addr_lo),
      .i_funct3  (r_funct3),
      .o_data    (w_load_data)
   );

   // Outputs are decoded into registers alongside the state so that reset
   // clears them immediately and they never glitch on input changes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_we       <= 1'b0;
         r_funct3   <= 3'b000;
         r_addr_lo  <= 2'b00;
         r_addr     <= '0;
         r_be       <= 4'b0000;
         r_wdata    <= 32'h0;
         r_rdata    <= '0;
         r_req      <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_misalign <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (lsu_valid) begin
                  r_we      <= lsu_we;
                  r_funct3  <= funct3;
                  r_addr_lo <= alu_output[1:0];
                  r_addr    <= {alu_output[ADDR_W-1:2], 2'b00};
                  r_be      <= lsu_we ? store_be(funct3[1:0], alu_output[1:0]) : c_be_word;
                  r_wdata   <= store_wdata(funct3[1:0], store_data);
                  r_busy    <= 1'b1;
                  if (w_err) begin
                     r_done     <= 1'b1;
                     r_misalign <= 1'b1;
                     r_state    <= ST_RESP;
                  end else begin
                     r_req   <= 1'b1;
                     r_state <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (dmem.dmem_gnt) begin
                  r_req <= 1'b0;
                  if (r_we) begin
                     r_done  <= 1'b1;
                     r_state <= ST_RESP;
                  end else begin
                     r_state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (dmem.dmem_rvalid) begin
                  r_rdata <= w_load_data;
                  r_done  <= 1'b1;
                  r_state <= ST_RESP;
               end
            end
            ST_RESP: begin
               r_done     <= 1'b0;
               r_misalign <= 1'b0;
               r_busy     <= 1'b0;
               r_state    <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign lsu_busy        = r_busy;
   assign lsu_done        = r_done;
   assign misalign_err    = r_misalign;
   assign Mem_ReadData    = r_rdata;
   assign dmem.dmem_req   = r_req;
   assign dmem.dmem_we    = r_we;
   assign dmem.dmem_addr  = r_addr;
   assign dmem.dmem_be    = r_be;
   assign dmem.dmem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_load_store_unit                                                         |
// | Directed accesses checked every cycle against a transaction-level model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        lsu_valid;
   logic        lsu_we;
   logic [2:0]  funct3;
   logic [31:0] alu_output;
   logic [31:0] store_data;
   logic        lsu_busy;
   logic        lsu_done;
   logic        misalign_err;
   logic [31:0] Mem_ReadData;

   load_store_unit_if #(.ADDR_W(32)) dmem ();

   load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .lsu_valid    (lsu_valid),
      .lsu_we       (lsu_we),
      .funct3       (funct3),
      .alu_output   (alu_output),
      .store_data   (store_data),
      .lsu_busy     (lsu_busy),
      .lsu_done     (lsu_done),
      .misalign_err (misalign_err),
      .Mem_ReadData (Mem_ReadData),
      .dmem         (dmem)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Expected per-cycle view, written by the stimulus, read by the checker.
   bit          check_en = 1'b0;
   bit          m_busy, m_done, m_err, m_req, m_we;
   logic [31:0] m_rd, m_addr, m_wdata;
   logic [3:0]  m_be;
   int          cur_c, done_at;
   bit          req_seen;
   logic [31:0] last_addr, last_wdata;
   logic [3:0]  last_be;
   logic        last_we;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic bit exp_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
      case (f3)
         3'd0: return 1'b0;
         3'd1: return a[0];
         3'd2: return a[1:0] != 2'd0;
         3'd4: return we;
         3'd5: return we || a[0];
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] rd);
      logic [31:0] w;
      w = rd >> (8 * a[1:0]);
      case (f3)
         3'd0: return {{24{w[7]}}, w[7:0]};
         3'd1: return {{16{w[15]}}, w[15:0]};
         3'd4: return {24'h0, w[7:0]};
         3'd5: return {16'h0, w[15:0]};
         default: return rd;
      endcase
   endfunction

   function automatic logic [3:0] exp_be(input logic we, input logic [2:0] f3, input logic [31:0] a);
      if (!we) return 4'hF;
      case (f3)
         3'd0: return 4'b0001 << a[1:0];
         3'd1: return 4'b0011 << (2 * a[1]);
         default: return 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
      case (f3)
         3'd0: return {24'h0, d[7:0]} * 32'h01010101;
         3'd1: return {16'h0, d[15:0]} * 32'h00010001;
         default: return d;
      endcase
   endfunction

   // Single compare process: every cycle, DUT outputs against the model.
   always @(negedge clk) begin
      if (dmem.dmem_req) begin
         req_seen   = 1'b1;
         last_addr  = dmem.dmem_addr;
         last_be    = dmem.dmem_be;
         last_wdata = dmem.dmem_wdata;
         last_we    = dmem.dmem_we;
      end
      if (check_en) begin
         chk("lsu_busy",     32'(lsu_busy),      32'(m_busy));
         chk("lsu_done",     32'(lsu_done),      32'(m_done));
         chk("misalign_err", 32'(misalign_err),  32'(m_err));
         chk("dmem_req",     32'(dmem.dmem_req), 32'(m_req));
         chk("Mem_ReadData", Mem_ReadData,       m_rd);
         if (m_req) begin
            chk("dmem_addr",  dmem.dmem_addr,      m_addr);
            chk("dmem_be",    32'(dmem.dmem_be),   32'(m_be));
            chk("dmem_wdata", dmem.dmem_wdata,     m_wdata);
            chk("dmem_we",    32'(dmem.dmem_we),   32'(m_we));
         end
         if (lsu_done) done_at = cur_c;
      end
   end

   task automatic set_idle();
      m_busy = 0; m_done = 0; m_err = 0; m_req = 0; cur_c = 0;
   endtask

   // One access: lsu_valid in cycle 0, memory grants after gdly wait cycles,
   // rvalid the cycle after the grant. poke re-pulses lsu_valid while busy.
   task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rd,
                         input int gdly, input bit poke);
      bit err;
      int n_cyc;
      err = exp_err(we, f3, a);
      n_cyc = err ? 1 : (we ? gdly + 2 : gdly + 3);
      done_at = -1;
      req_seen = 1'b0;
      @(posedge clk); #1;
      lsu_valid = 1'b1; lsu_we = we; funct3 = f3; alu_output = a; store_data = sd;
      set_idle();
      for (int c = 1; c <= n_cyc; c++) begin
         @(posedge clk); #1;
         cur_c = c;
         lsu_valid = poke && (c == 2);
         if (poke && c == 2) begin
            alu_output = 32'h0000_03FC; lsu_we = ~we; store_data = 32'h5A5A_5A5A;
         end
         dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0; dmem.dmem_rdata = 32'hBAD0_BAD0;
         m_busy = 1'b1;
         m_done = (c == n_cyc);
         m_err  = err && (c == n_cyc);
         m_req  = !err && (c <= gdly + 1);
         if (m_req) begin
            m_addr  = {a[31:2], 2'b00};
            m_be    = exp_be(we, f3, a);
            m_wdata = exp_wdata(f3, sd);
            m_we    = we;
            dmem.dmem_gnt = (c == gdly + 1);
            dmem.dmem_rvalid = (c <= gdly);   // stray rvalid before grant must be ignored
         end
         if (!err && !we && c == gdly + 2) begin
            dmem.dmem_rvalid = 1'b1; dmem.dmem_rdata = rd;
         end
         if (m_done && !err && !we) m_rd = exp_load(f3, a, rd);
      end
      @(posedge clk); #1;
      lsu_valid = 1'b0; dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0;
      set_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; lsu_valid = 1'b0; lsu_we = 1'b0; funct3 = 3'd0;
      alu_output = 32'h0; store_data = 32'h0;
      dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0; dmem.dmem_rdata = 32'h0;
      m_rd = 32'h0; m_addr = 32'h0; m_wdata = 32'h0; m_be = 4'h0; m_we = 1'b0;
      set_idle();
      done_at = -1; req_seen = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy",  32'(lsu_busy),        32'd0);
      chk("rst_done",  32'(lsu_done),        32'd0);
      chk("rst_err",   32'(misalign_err),    32'd0);
      chk("rst_rdata", Mem_ReadData,         32'd0);
      chk("rst_req",   32'(dmem.dmem_req),   32'd0);
      chk("rst_we",    32'(dmem.dmem_we),    32'd0);
      chk("rst_addr",  dmem.dmem_addr,       32'd0);
      chk("rst_be",    32'(dmem.dmem_be),    32'd0);
      chk("rst_wdata", dmem.dmem_wdata,      32'd0);
      rst_n = 1'b1;
      check_en = 1'b1;

      // Loads, zero-wait memory
      access(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0);
      chk("lw_rdata",      Mem_ReadData,     32'hDEADBEEF);
      chk("lw_done_cycle", 32'(done_at),     32'd3);
      chk("lw_addr",       last_addr,        32'h100);
      chk("lw_be",         32'(last_be),     32'hF);
      access(1'b0, 3'd0, 32'h103, 32'h0, 32'h80112233, 0, 1'b0);
      chk("lb_rdata",  Mem_ReadData, 32'hFFFFFF80);
      access(1'b0, 3'd4, 32'h103, 32'h0, 32'h80112233, 0, 1'b0);
      chk("lbu_rdata", Mem_ReadData, 32'h00000080);
      access(1'b0, 3'd1, 32'h102, 32'h0, 32'h80112233, 0, 1'b0);
      chk("lh_rdata",  Mem_ReadData, 32'hFFFF8011);
      access(1'b0, 3'd5, 32'h100, 32'h0, 32'h0000F00D, 0, 1'b0);
      chk("lhu_rdata", Mem_ReadData, 32'h0000F00D);
      access(1'b0, 3'd0, 32'h101, 32'h0, 32'h0000_7F00, 0, 1'b0);
      chk("lb_pos_rdata", Mem_ReadData, 32'h0000007F);

      // Stores
      access(1'b1, 3'd1, 32'h202, 32'h1234ABCD, 32'h0, 0, 1'b0);
      chk("sh_addr",       last_addr,       32'h200);
      chk("sh_be",         32'(last_be),    32'hC);
      chk("sh_wdata",      last_wdata,      32'hABCDABCD);
      chk("sh_we",         32'(last_we),    32'd1);
      chk("sh_done_cycle", 32'(done_at),    32'd2);
      chk("sh_keeps_rd",   Mem_ReadData,    32'h0000007F);
      access(1'b1, 3'd0, 32'h301, 32'h00000055, 32'h0, 0, 1'b0);
      chk("sb_be",    32'(last_be), 32'h2);
      chk("sb_wdata", last_wdata,   32'h55555555);
      access(1'b1, 3'd2, 32'h30C, 32'h01234567, 32'h0, 1, 1'b0);

      // Errors: no memory access, done+err in cycle 1
      access(1'b0, 3'd2, 32'h102, 32'h0, 32'h0, 0, 1'b0);
      chk("mis_done_cycle", 32'(done_at),  32'd1);
      chk("mis_no_req",     32'(req_seen), 32'd0);
      chk("mis_keeps_rd",   Mem_ReadData,  32'h0000007F);
      access(1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 0, 1'b0);
      chk("f3_011_done_cycle", 32'(done_at),  32'd1);
      chk("f3_011_no_req",     32'(req_seen), 32'd0);
      access(1'b1, 3'd4, 32'h100, 32'h0, 32'h0, 0, 1'b0);
      access(1'b1, 3'd2, 32'h206, 32'h0, 32'h0, 0, 1'b0);

      // Delayed grant with an ignored lsu_valid pulse while busy
      access(1'b0, 3'd2, 32'h108, 32'h0, 32'h01020304, 3, 1'b1);
      chk("slow_done_cycle", 32'(done_at), 32'd6);
      chk("slow_rdata",      Mem_ReadData, 32'h01020304);
      chk("slow_addr",       last_addr,    32'h108);
      access(1'b1, 3'd1, 32'h40, 32'hFFFF8001, 32'h0, 2, 1'b1);
      chk("slow_sh_done_cycle", 32'(done_at), 32'd4);

      // Reset while waiting for rvalid
      check_en = 1'b0;
      @(posedge clk); #1;
      lsu_valid = 1'b1; lsu_we = 1'b0; funct3 = 3'd2; alu_output = 32'h100;
      @(posedge clk); #1;
      lsu_valid = 1'b0; dmem.dmem_gnt = 1'b1;
      chk("mid_req_before_rst", 32'(dmem.dmem_req), 32'd1);
      @(posedge clk); #1;
      dmem.dmem_gnt = 1'b0;
      chk("mid_busy_before_rst", 32'(lsu_busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy",  32'(lsu_busy),      32'd0);
      chk("mid_rst_req",   32'(dmem.dmem_req), 32'd0);
      chk("mid_rst_addr",  dmem.dmem_addr,     32'd0);
      chk("mid_rst_rdata", Mem_ReadData,       32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      dmem.dmem_rvalid = 1'b1; dmem.dmem_rdata = 32'h11111111;
      @(posedge clk); #1;
      dmem.dmem_rvalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("post_rst_done",  32'(lsu_done), 32'd0);
         chk("post_rst_busy",  32'(lsu_busy), 32'd0);
         chk("post_rst_rdata", Mem_ReadData,  32'd0);
         @(posedge clk); #1;
      end
      m_rd = 32'h0;
      set_idle();
      check_en = 1'b1;
      access(1'b0, 3'd2, 32'h104, 32'h0, 32'hCAFEF00D, 0, 1'b0);
      chk("after_rst_rdata",      Mem_ReadData, 32'hCAFEF00D);
      chk("after_rst_done_cycle", 32'(done_at), 32'd3);
      chk("after_rst_addr",       last_addr,    32'h104);

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
